// File: rtl/types_def.sv
// types_def: shared encodings between the burst handler and the DDR5 command path.
package types_def;

    typedef enum logic [2:0] {
        none,
        activate,
        read_cmd,
        write_cmd,
        precharge
    } command;

    typedef enum logic [1:0] {
        empty,
        filling,
        full
    } burst_states_type;

    typedef enum logic {
        read,
        write
    } r_type;

endpackage

// File: rtl/burst_cmd_scheduler.sv
// burst_cmd_scheduler: single-bank command sequencer.
// Picks the next full burst and issues activate / read / write / precharge with
// tRCD, tRP and tCCD spacing, tracking the open row.
// Build option BURST_SCHED_OPEN_PAGE_EN: open-page policy (row-hit priority,
// precharge only on a miss). Left undefined: closed-page policy, where every
// column command is followed by a precharge T_CCD later.
module burst_cmd_scheduler
    import types_def::*;
#(
    parameter int unsigned NO_OF_BURSTS = 4,
    parameter int unsigned ROW_W        = 16,
    parameter int unsigned T_RCD        = 8,
    parameter int unsigned T_RP         = 8,
    parameter int unsigned T_CCD        = 4,
    localparam int unsigned IDX_W       = $clog2(NO_OF_BURSTS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  burst_states_type burst_state [NO_OF_BURSTS],
    input  r_type            burst_type  [NO_OF_BURSTS],
    input  logic [ROW_W-1:0] burst_row   [NO_OF_BURSTS],
    output command           out_cmd,
    output logic [IDX_W-1:0] out_cmd_index,
    output logic             open_row_valid,
    output logic [ROW_W-1:0] open_row
);

    localparam int unsigned T_MAX0 = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned T_MAX  = (T_MAX0 > T_CCD) ? T_MAX0 : T_CCD;
    localparam int unsigned CNT_W  = $clog2(T_MAX) + 1;

    // Counters hold "cycles left - 1" so the command fires on the edge they read 0.
    localparam logic [CNT_W-1:0] RCD_LOAD = CNT_W'(T_RCD - 1);
    localparam logic [CNT_W-1:0] RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] CCD_LOAD = CNT_W'(T_CCD - 1);

    typedef enum logic [1:0] {StIdle, StPreWait, StActWait, StColWait} state_e;

    state_e                  state_q, state_d;
    logic [NO_OF_BURSTS-1:0] issued_q;
    logic [IDX_W-1:0]        rr_ptr_q, sel_q, sel_c, scan_idx;
    logic [IDX_W-1:0]        col_idx, act_idx, pre_idx, cmd_idx_d, out_idx_q;
    logic                    sel_valid, sel_latch;
    int unsigned             scan_pos;
    logic [CNT_W-1:0]        ccd_cnt_q, wait_cnt_q;
    logic                    ccd_zero, wait_zero;
    logic                    idle_col, idle_pre, idle_act;
    logic                    col_fire, act_fire, pre_fire;
    command                  cmd_d, out_cmd_q;
    logic                    open_row_valid_q;
    logic [ROW_W-1:0]        open_row_q;
`ifdef BURST_SCHED_OPEN_PAGE_EN
    logic                    sel_hit;
    logic [IDX_W-1:0]        hit_c;
`endif

    assign ccd_zero = (ccd_cnt_q == '0);
    assign wait_zero = (wait_cnt_q == '0);

    // Round-robin scan from rr_ptr; open page prefers bursts hitting the open row.
    always_comb begin
        sel_c     = '0;
        sel_valid = 1'b0;
        scan_pos  = 0;
        scan_idx  = '0;
`ifdef BURST_SCHED_OPEN_PAGE_EN
        sel_hit   = 1'b0;
        hit_c     = '0;
`endif
        for (int unsigned k = 0; k < NO_OF_BURSTS; k++) begin
            scan_pos = 32'(rr_ptr_q) + k;
            if (scan_pos >= NO_OF_BURSTS) scan_pos = scan_pos - NO_OF_BURSTS;
            scan_idx = IDX_W'(scan_pos);
            if (burst_state[scan_idx] == full && !issued_q[scan_idx]) begin
                if (!sel_valid) begin
                    sel_valid = 1'b1;
                    sel_c     = scan_idx;
                end
`ifdef BURST_SCHED_OPEN_PAGE_EN
                if (!sel_hit && open_row_valid_q && burst_row[scan_idx] == open_row_q) begin
                    sel_hit = 1'b1;
                    hit_c   = scan_idx;
                end
`endif
            end
        end
`ifdef BURST_SCHED_OPEN_PAGE_EN
        if (sel_hit) sel_c = hit_c;
`endif
    end

`ifdef BURST_SCHED_OPEN_PAGE_EN
    assign idle_col = sel_valid && sel_hit && ccd_zero;
    assign idle_pre = sel_valid && !sel_hit && open_row_valid_q && ccd_zero;
    assign idle_act = sel_valid && !sel_hit && !open_row_valid_q;
`else
    // Closed page: a row is only ever open between its column command and precharge.
    assign idle_col = 1'b0;
    assign idle_pre = open_row_valid_q && ccd_zero;
    assign idle_act = sel_valid && !open_row_valid_q;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (idle_col)      state_d = StColWait;
                else if (idle_pre) state_d = StPreWait;
                else if (idle_act) state_d = StActWait;
            end
            StPreWait: begin
`ifdef BURST_SCHED_OPEN_PAGE_EN
                if (wait_zero) state_d = StActWait;
`else
                if (wait_zero) state_d = sel_valid ? StActWait : StIdle;
`endif
            end
            StActWait: if (wait_zero) state_d = StColWait;
            StColWait: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs: command strobes and the next registered command
    always_comb begin
        col_fire  = 1'b0;
        act_fire  = 1'b0;
        pre_fire  = 1'b0;
        sel_latch = 1'b0;
        col_idx   = sel_q;
        act_idx   = sel_q;
        pre_idx   = sel_q;
        cmd_d     = none;
        cmd_idx_d = '0;
        case (state_q)
            StIdle: begin
                if (idle_col) begin
                    col_fire  = 1'b1;
                    col_idx   = sel_c;
                    sel_latch = 1'b1;
                end else if (idle_pre) begin
                    pre_fire  = 1'b1;
`ifdef BURST_SCHED_OPEN_PAGE_EN
                    pre_idx   = sel_c;
                    sel_latch = 1'b1;
`endif
                end else if (idle_act) begin
                    act_fire  = 1'b1;
                    act_idx   = sel_c;
                    sel_latch = 1'b1;
                end
            end
            StPreWait: begin
`ifdef BURST_SCHED_OPEN_PAGE_EN
                if (wait_zero) act_fire = 1'b1;
`else
                if (wait_zero && sel_valid) begin
                    act_fire  = 1'b1;
                    act_idx   = sel_c;
                    sel_latch = 1'b1;
                end
`endif
            end
            StActWait: if (wait_zero) col_fire = 1'b1;
            default: ;
        endcase
        if (col_fire) begin
            cmd_d     = (burst_type[col_idx] == write) ? write_cmd : read_cmd;
            cmd_idx_d = col_idx;
        end else if (act_fire) begin
            cmd_d     = activate;
            cmd_idx_d = act_idx;
        end else if (pre_fire) begin
            cmd_d     = precharge;
            cmd_idx_d = pre_idx;
        end
    end

    // Registered outputs, timing counters, open-row and per-burst issue tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_cmd_q        <= none;
            out_idx_q        <= '0;
            open_row_valid_q <= 1'b0;
            open_row_q       <= '0;
            issued_q         <= '0;
            rr_ptr_q         <= '0;
            sel_q            <= '0;
            ccd_cnt_q        <= '0;
            wait_cnt_q       <= '0;
        end else begin
            out_cmd_q <= cmd_d;
            out_idx_q <= cmd_idx_d;
            if (sel_latch) sel_q <= sel_c;

            if (col_fire)       ccd_cnt_q <= CCD_LOAD;
            else if (!ccd_zero) ccd_cnt_q <= ccd_cnt_q - CNT_W'(1);

            if (pre_fire)        wait_cnt_q <= RP_LOAD;
            else if (act_fire)   wait_cnt_q <= RCD_LOAD;
            else if (!wait_zero) wait_cnt_q <= wait_cnt_q - CNT_W'(1);

            if (act_fire) begin
                open_row_q       <= burst_row[act_idx];
                open_row_valid_q <= 1'b1;
            end else if (pre_fire) begin
                open_row_valid_q <= 1'b0;
            end

            if (col_fire) begin
                rr_ptr_q <= (32'(col_idx) == NO_OF_BURSTS - 1) ? '0 : col_idx + IDX_W'(1);
            end

            // Set needs full and clear needs empty, so they never collide.
            for (int unsigned i = 0; i < NO_OF_BURSTS; i++) begin
                if (col_fire && col_idx == IDX_W'(i))        issued_q[i] <= 1'b1;
                else if (burst_state[IDX_W'(i)] == empty)    issued_q[i] <= 1'b0;
            end
        end
    end

    assign out_cmd        = out_cmd_q;
    assign out_cmd_index  = out_idx_q;
    assign open_row_valid = open_row_valid_q;
    assign open_row       = open_row_q;

endmodule

// File: tb/tb_burst_cmd_scheduler.sv
// tb_burst_cmd_scheduler: directed bench with a scoreboard of expected commands
// (command, index, cycle), compared whenever the scheduler emits a command.
module tb_burst_cmd_scheduler;
    import types_def::*;

    localparam int NB    = 4;
    localparam int ROW_W = 16;
    localparam int T_RCD = 8;
    localparam int T_RP  = 8;
    localparam int T_CCD = 4;

    typedef struct {
        command cmd;
        int     idx;
        int     cyc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    burst_states_type burst_state [NB];
    r_type            burst_type  [NB];
    logic [ROW_W-1:0] burst_row   [NB];
    command           out_cmd;
    logic [1:0]       out_cmd_index;
    logic             open_row_valid;
    logic [ROW_W-1:0] open_row;

    exp_t exp_q[$];
    int   cyc;
    int   n_assert;
    int   n_fail;
    int   n;
    int   a;
`ifndef BURST_SCHED_OPEN_PAGE_EN
    int   rr_order [3];
`endif

    burst_cmd_scheduler #(
        .NO_OF_BURSTS(NB),
        .ROW_W       (ROW_W),
        .T_RCD       (T_RCD),
        .T_RP        (T_RP),
        .T_CCD       (T_CCD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .burst_state   (burst_state),
        .burst_type    (burst_type),
        .burst_row     (burst_row),
        .out_cmd       (out_cmd),
        .out_cmd_index (out_cmd_index),
        .open_row_valid(open_row_valid),
        .open_row      (open_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic push(input command c, input int idx, input int at);
        exp_t e;
        e.cmd = c;
        e.idx = idx;
        e.cyc = at;
        exp_q.push_back(e);
    endtask

    task automatic set_burst(input int i, input burst_states_type s, input r_type t,
                             input logic [ROW_W-1:0] row);
        burst_state[i] = s;
        burst_type[i]  = t;
        burst_row[i]   = row;
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (out_cmd !== none) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", out_cmd, none);
            end else begin
                e = exp_q.pop_front();
                check("cmd", out_cmd, e.cmd);
                check("cmd_index", out_cmd_index, e.idx);
                check("cmd_cycle", cyc, e.cyc);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cyc      = 0;
        n_assert = 0;
        n_fail   = 0;
        for (int i = 0; i < NB; i++) set_burst(i, empty, read, '0);

        // Reset values
        repeat (3) tick();
        check("rst_cmd", out_cmd, none);
        check("rst_index", out_cmd_index, 0);
        check("rst_row_valid", open_row_valid, 1'b0);
        check("rst_row", open_row, 0);
        rst_n = 1'b1;

        // All empty: nothing issued
        repeat (50) tick();
        check("idle_row_valid", open_row_valid, 1'b0);

        // Cold miss: burst 2 write, row 0x12
        set_burst(2, full, write, 16'h0012);
        n = cyc;
        push(activate, 2, n + 1);
        push(write_cmd, 2, n + 1 + T_RCD);
`ifndef BURST_SCHED_OPEN_PAGE_EN
        push(precharge, 2, n + 1 + T_RCD + T_CCD);
`endif
        tick();
        check("act_open_row", open_row, 16'h0012);
        check("act_row_valid", open_row_valid, 1'b1);
        repeat (40) tick();
        check("cold_drained", exp_q.size(), 0);
`ifdef BURST_SCHED_OPEN_PAGE_EN
        check("cold_row_still_open", open_row_valid, 1'b1);
`else
        check("cold_row_closed", open_row_valid, 1'b0);
`endif
        set_burst(2, empty, read, '0);
        repeat (2) tick();

`ifdef BURST_SCHED_OPEN_PAGE_EN
        // Row 0x12 open: burst 3 hits and goes first, burst 0 misses
        set_burst(0, full, read, 16'h0040);
        set_burst(3, full, write, 16'h0012);
        n = cyc;
        push(write_cmd, 3, n + 1);
        push(precharge, 0, n + 1 + T_CCD);
        push(activate, 0, n + 1 + T_CCD + T_RP);
        push(read_cmd, 0, n + 1 + T_CCD + T_RP + T_RCD);
        repeat (30) tick();
        check("miss_open_row", open_row, 16'h0040);
        check("miss_row_valid", open_row_valid, 1'b1);
        set_burst(0, empty, read, '0);
        set_burst(3, empty, read, '0);
        repeat (2) tick();

        // Single hit on burst 3 moves the pointer back to 0
        set_burst(3, full, read, 16'h0040);
        n = cyc;
        push(read_cmd, 3, n + 1);
        repeat (6) tick();
        set_burst(3, empty, read, '0);
        repeat (2) tick();

        // Four hits together: spaced T_CCD, order 0,1,2,3
        for (int i = 0; i < NB; i++) set_burst(i, full, (i % 2 == 1) ? write : read, 16'h0040);
        n = cyc;
        for (int i = 0; i < NB; i++) push((i % 2 == 1) ? write_cmd : read_cmd, i, n + 1 + i * T_CCD);
        repeat (20) tick();
        check("hits_drained", exp_q.size(), 0);
        for (int i = 0; i < NB; i++) set_burst(i, empty, read, '0);
        repeat (2) tick();
`else
        // Three bursts at once: round-robin from burst 3, each closed after use
        set_burst(0, full, read, 16'h0100);
        set_burst(1, full, write, 16'h0101);
        set_burst(3, full, read, 16'h0103);
        rr_order = '{3, 0, 1};
        a = cyc + 1;
        for (int k = 0; k < 3; k++) begin
            push(activate, rr_order[k], a);
            push((rr_order[k] == 1) ? write_cmd : read_cmd, rr_order[k], a + T_RCD);
            push(precharge, rr_order[k], a + T_RCD + T_CCD);
            a = a + T_RCD + T_CCD + T_RP;
        end
        tick();
        check("rr_first_row", open_row, 16'h0103);
        repeat (65) tick();
        check("rr_drained", exp_q.size(), 0);
        check("rr_row_closed", open_row_valid, 1'b0);
        set_burst(0, empty, read, '0);
        set_burst(1, empty, read, '0);
        set_burst(3, empty, read, '0);
        repeat (2) tick();
`endif

        // Reset three cycles into ACT_WAIT, then restart from activate
        set_burst(0, full, read, 16'h0077);
        n = cyc;
`ifdef BURST_SCHED_OPEN_PAGE_EN
        push(precharge, 0, n + 1);
        a = n + 1 + T_RP;
`else
        a = n + 1;
`endif
        push(activate, 0, a);
        repeat (a + 3 - cyc) tick();
        check("pre_reset_row_valid", open_row_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_cmd", out_cmd, none);
        check("async_rst_index", out_cmd_index, 0);
        check("async_rst_row_valid", open_row_valid, 1'b0);
        check("async_rst_row", open_row, 0);
        check("pending_at_reset", exp_q.size(), 0);
        repeat (2) tick();
        rst_n = 1'b1;
        n = cyc;
        push(activate, 0, n + 1);
        push(read_cmd, 0, n + 1 + T_RCD);
`ifndef BURST_SCHED_OPEN_PAGE_EN
        push(precharge, 0, n + 1 + T_RCD + T_CCD);
`endif
        tick();
        check("restart_row", open_row, 16'h0077);
        repeat (20) tick();
        set_burst(0, empty, read, '0);
        repeat (2) tick();
        check("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
